// File: rtl/conv_2d_coef_loader.sv
// Streams N = WIN_SIZE^2 signed coefficients into a conv_2d CSR bank over AXI4-Lite, then writes the apply register.
// One write outstanding at a time; any stall on the coefficient stream or AW/W/B only lengthens the current state.
module conv_2d_coef_loader #(
    parameter logic [31:0] CSR_BASE_ADDR = 32'h0,
    parameter int unsigned COEF_WIDTH    = 13,
    parameter int unsigned WIN_SIZE      = 5,
    parameter logic [31:0] APPLY_OFFSET  = 32'h100
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [COEF_WIDTH-1:0] coef_i_tdata,
    input  logic                  coef_i_tvalid,
    output logic                  coef_i_tready,
    output logic                  csr_awvalid,
    input  logic                  csr_awready,
    output logic [31:0]           csr_awaddr,
    output logic [2:0]            csr_awprot,
    output logic                  csr_wvalid,
    input  logic                  csr_wready,
    output logic [31:0]           csr_wdata,
    output logic [3:0]            csr_wstrb,
    input  logic                  csr_bvalid,
    output logic                  csr_bready,
    input  logic [1:0]            csr_bresp,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    localparam int unsigned   N      = WIN_SIZE * WIN_SIZE;
    localparam int unsigned   KW     = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_FETCH      = 3'd1;
    localparam logic [2:0] S_WRITE      = 3'd2;
    localparam logic [2:0] S_RESP       = 3'd3;
    localparam logic [2:0] S_APPLY      = 3'd4;
    localparam logic [2:0] S_APPLY_RESP = 3'd5;
    localparam logic [2:0] S_DONE       = 3'd6;

    logic [2:0]    state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic          awvalid_q, awvalid_d;
    logic          wvalid_q, wvalid_d;
    logic [31:0]   awaddr_q, awaddr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          err_q, err_d;
    logic          aw_left, w_left;

    // A channel's valid survives the edge only if its ready was low this cycle.
    assign aw_left = awvalid_q & ~csr_awready;
    assign w_left  = wvalid_q & ~csr_wready;

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_FETCH;
                    k_d     = '0;
                    err_d   = 1'b0;
                end
            end
            S_FETCH: begin
                if (coef_i_tvalid) begin
                    state_d   = S_WRITE;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    awaddr_d  = CSR_BASE_ADDR + (32'(k_q) << 2);
                    wdata_d   = {{(32 - COEF_WIDTH){coef_i_tdata[COEF_WIDTH-1]}}, coef_i_tdata};
                end
            end
            S_WRITE, S_APPLY: begin
                awvalid_d = aw_left;
                wvalid_d  = w_left;
                if (!aw_left && !w_left) begin
                    state_d = (state_q == S_WRITE) ? S_RESP : S_APPLY_RESP;
                end
            end
            S_RESP: begin
                if (csr_bvalid) begin
                    if (csr_bresp != 2'b00) err_d = 1'b1;
                    if (k_q == K_LAST) begin
                        state_d   = S_APPLY;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        awaddr_d  = CSR_BASE_ADDR + APPLY_OFFSET;
                        wdata_d   = 32'h1;
                    end else begin
                        state_d = S_FETCH;
                        k_d     = k_q + 1'b1;
                    end
                end
            end
            S_APPLY_RESP: begin
                if (csr_bvalid) begin
                    if (csr_bresp != 2'b00) err_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
        end
    end

    assign coef_i_tready = (state_q == S_FETCH);
    assign csr_awvalid   = awvalid_q;
    assign csr_awaddr    = awaddr_q;
    assign csr_awprot    = 3'b000;
    assign csr_wvalid    = wvalid_q;
    assign csr_wdata     = wdata_q;
    assign csr_wstrb     = 4'hF;
    assign csr_bready    = (state_q == S_RESP) || (state_q == S_APPLY_RESP);
    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = (state_q == S_DONE);
    assign err_o         = err_q;

endmodule

// File: tb/tb_conv_2d_coef_loader.sv
// Bench for conv_2d_coef_loader: randomized AXI-Lite slave and coefficient source, with the
// expected write list rebuilt from the coefficient values pushed into the source.
module tb_conv_2d_coef_loader;

    localparam logic [31:0] BASE = 32'h40;
    localparam int          N    = 9;

    typedef struct {
        int unsigned aw_pct;
        int unsigned w_pct;
        int unsigned b_pct;
        int unsigned gap_pct;
        int          bad_k;
        bit          fixed;
        bit          extra_start;
        bit          exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [12:0] coef_tdata;
    logic        coef_tvalid;
    logic        coef_tready;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [31:0] awaddr, wdata;
    logic [2:0]  awprot;
    logic [3:0]  wstrb;
    logic [1:0]  bresp;
    logic        busy, done, err;

    int n_chk = 0;
    int n_fail = 0;

    int unsigned aw_pct, w_pct, b_pct, gap_pct;
    int          bad_k;
    bit          manual, man_aw, man_w;
    int          src_q[$];
    int          exp_coef[$];
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    int          aw_n, w_n, b_n, done_cnt, proto_err, err_viol;
    bit          bad_seen;
    bit          aw_fire, w_fire, b_fire, c_fire, pv_aw, pv_w;
    logic [31:0] pv_awaddr, pv_wdata;

    conv_2d_coef_loader #(
        .CSR_BASE_ADDR(BASE),
        .COEF_WIDTH   (13),
        .WIN_SIZE     (3),
        .APPLY_OFFSET (32'h100)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .coef_i_tdata (coef_tdata),
        .coef_i_tvalid(coef_tvalid),
        .coef_i_tready(coef_tready),
        .csr_awvalid  (awvalid),
        .csr_awready  (awready),
        .csr_awaddr   (awaddr),
        .csr_awprot   (awprot),
        .csr_wvalid   (wvalid),
        .csr_wready   (wready),
        .csr_wdata    (wdata),
        .csr_wstrb    (wstrb),
        .csr_bvalid   (bvalid),
        .csr_bready   (bready),
        .csr_bresp    (bresp),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Runs once per falling edge: evaluates what happened at the previous rising edge,
    // then drives the inputs the next rising edge will sample.
    task automatic bfm_step();
        int c;
        if (rst) begin
            src_q.delete(); log_addr.delete(); log_data.delete();
            aw_n = 0; w_n = 0; b_n = 0;
            coef_tvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
            aw_fire = 0; w_fire = 0; b_fire = 0; c_fire = 0; pv_aw = 0; pv_w = 0;
            return;
        end
        if (pv_aw && !aw_fire && (!awvalid || awaddr !== pv_awaddr)) proto_err++;
        if (pv_w && !w_fire && (!wvalid || wdata !== pv_wdata)) proto_err++;
        if (c_fire) void'(src_q.pop_front());
        if (b_fire) begin bvalid = 1'b0; bresp = 2'b00; end
        if (busy && err !== bad_seen) err_viol++;
        if (done) done_cnt++;

        awready = manual ? man_aw : ($urandom_range(99) >= aw_pct);
        wready  = manual ? man_w  : ($urandom_range(99) >= w_pct);
        if (!(coef_tvalid && !c_fire)) begin
            coef_tvalid = (src_q.size() > 0) && ($urandom_range(99) >= gap_pct);
            if (coef_tvalid) begin c = src_q[0]; coef_tdata = 13'(c); end
        end
        if (!bvalid && aw_n > b_n && w_n > b_n && $urandom_range(99) >= b_pct) begin
            bvalid = 1'b1;
            bresp  = (b_n == bad_k) ? 2'b10 : 2'b00;
        end

        aw_fire = awvalid && awready;
        w_fire  = wvalid && wready;
        c_fire  = coef_tvalid && coef_tready;
        b_fire  = bvalid && bready;
        if (aw_fire) begin log_addr.push_back(awaddr); aw_n++; end
        if (w_fire) begin log_data.push_back(wdata); w_n++; end
        if (b_fire) begin b_n++; if (bresp != 2'b00) bad_seen = 1'b1; end
        if (aw_n - b_n > 1 || w_n - b_n > 1) proto_err++;
        pv_aw = awvalid; pv_awaddr = awaddr;
        pv_w  = wvalid;  pv_wdata  = wdata;
    endtask

    initial forever begin
        @(negedge clk);
        bfm_step();
    end

    task automatic prep_run(input vec_t v);
        int c;
        aw_pct = v.aw_pct; w_pct = v.w_pct; b_pct = v.b_pct; gap_pct = v.gap_pct;
        bad_k = v.bad_k; manual = 1'b0;
        exp_coef.delete(); src_q.delete(); log_addr.delete(); log_data.delete();
        aw_n = 0; w_n = 0; b_n = 0; done_cnt = 0; proto_err = 0; err_viol = 0; bad_seen = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (v.fixed) c = (k == 0) ? -1 : k + 1;
            else         c = int'($urandom_range(8191)) - 4096;
            exp_coef.push_back(c);
            src_q.push_back(c);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
    endtask

    task automatic wait_done(input bit extra);
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk); #2;
            if (done_cnt > 0) break;
            start = extra && (cyc == 20);
        end
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " ctl"}, 32'({busy, done, err, awvalid, wvalid, bready, coef_tready}), 32'h0);
        chk({tag, " awaddr"}, awaddr, 32'h0);
        chk({tag, " wdata"}, wdata, 32'h0);
    endtask

    // Expected writes: coefficient k to BASE+4k sign-extended, then 1 to the apply register.
    task automatic check_run(input string tag, input bit exp_err);
        logic [31:0] ea, ed;
        chk({tag, " aw count"}, 32'(log_addr.size()), 32'(N + 1));
        chk({tag, " w count"}, 32'(log_data.size()), 32'(N + 1));
        chk({tag, " b count"}, 32'(b_n), 32'(N + 1));
        for (int k = 0; k <= N; k++) begin
            if (k < N) begin ea = BASE + 32'(4 * k); ed = 32'(exp_coef[k]); end
            else       begin ea = BASE + 32'h100;    ed = 32'h1; end
            if (k < log_addr.size()) chk($sformatf("%s addr[%0d]", tag, k), log_addr[k], ea);
            if (k < log_data.size()) chk($sformatf("%s data[%0d]", tag, k), log_data[k], ed);
        end
        chk({tag, " done pulses"}, 32'(done_cnt), 32'h1);
        chk({tag, " protocol"}, 32'(proto_err), 32'h0);
        chk({tag, " err timing"}, 32'(err_viol), 32'h0);
        chk({tag, " err final"}, 32'(err), 32'(exp_err));
        chk({tag, " idle after"}, 32'(busy), 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[6];
        vec_t        v;
        logic [31:0] a0;

        tbl[0] = '{0,  0,  0,  0,  -1, 1, 0, 0};
        tbl[1] = '{0,  0,  0,  0,  4,  0, 0, 1};
        tbl[2] = '{0,  0,  0,  60, -1, 0, 1, 0};
        tbl[3] = '{40, 40, 40, 30, -1, 0, 0, 0};
        tbl[4] = '{70, 20, 70, 0,  8,  0, 0, 1};
        tbl[5] = '{20, 70, 0,  0,  9,  0, 1, 1};

        rst = 1'b1; start = 1'b0; manual = 1'b0; man_aw = 1'b0; man_w = 1'b0;
        aw_pct = 0; w_pct = 0; b_pct = 0; gap_pct = 0; bad_k = -1;
        coef_tdata = '0; coef_tvalid = 1'b0; awready = 1'b0; wready = 1'b0;
        bvalid = 1'b0; bresp = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset");
        chk("awprot", 32'(awprot), 32'h0);
        chk("wstrb", 32'(wstrb), 32'hF);
        @(posedge clk); #2 rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            prep_run(tbl[i]);
            pulse_start();
            wait_done(tbl[i].extra_start);
            check_run($sformatf("vec%0d", i), tbl[i].exp_err);
        end

        // AW stalled five cycles while W is accepted immediately.
        v = tbl[0];
        v.fixed = 1'b0;
        prep_run(v);
        manual = 1'b1; man_aw = 1'b0; man_w = 1'b1;
        pulse_start();
        for (int i = 0; i < 50 && !awvalid; i++) begin @(posedge clk); #2; end
        chk("awstall enter", 32'({awvalid, wvalid}), 32'h3);
        a0 = awaddr;
        chk("awstall addr0", a0, BASE);
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk); #2;
            chk($sformatf("awstall valids c%0d", i), 32'({awvalid, wvalid}), 32'h2);
            chk($sformatf("awstall addr c%0d", i), awaddr, a0);
        end
        manual = 1'b0;
        wait_done(1'b0);
        check_run("awstall", 1'b0);

        // Reset in the middle of a write, then restart straight out of reset.
        prep_run(v);
        manual = 1'b1; man_aw = 1'b0; man_w = 1'b0;
        pulse_start();
        for (int i = 0; i < 50 && !awvalid; i++) begin @(posedge clk); #2; end
        @(posedge clk); #2;
        chk("midrst in write", 32'({awvalid, wvalid}), 32'h3);
        rst = 1'b1;
        #1 chk_reset("midrst async");
        repeat (2) @(posedge clk);
        #1 chk_reset("midrst held");
        @(posedge clk); #2;
        rst = 1'b0;
        prep_run(v);
        start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        chk("midrst start honoured", 32'({busy, coef_tready}), 32'h3);
        wait_done(1'b0);
        check_run("midrst", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_2d_coef_loader.md
CONV_2D_COEF_LOADER -- requirements
Module: conv_2d_coef_loader

Interface
REQ-001 SHALL have parameter CSR_BASE_ADDR, default 0, byte address of coefficient register 0 in the target conv_2d CSR map.
REQ-002 SHALL have parameter COEF_WIDTH, default 13, signed coefficient width in bits.
REQ-003 SHALL have parameter WIN_SIZE, default 5; coefficient count N = WIN_SIZE*WIN_SIZE.
REQ-004 SHALL have parameter APPLY_OFFSET, default 32'h100, byte offset from CSR_BASE_ADDR of the apply register.
REQ-005 SHALL use one clock and an asynchronous, active-high reset: clk_i is the single clock, rst_i is the asynchronous active-high reset.
REQ-006 Ports, as name, direction, width, meaning:
- clk_i  in  1  clock
- rst_i  in  1  async active-high reset
- start_i  in  1  begin one load sequence (sampled in IDLE only)
- coef_i_tdata  in  COEF_WIDTH  signed coefficient, index order 0..N-1
- coef_i_tvalid  in  1  coefficient valid
- coef_i_tready  out  1  coefficient accepted
- csr_awvalid / csr_awready  out / in  1  AXI4-Lite AW handshake
- csr_awaddr  out  32  write address
- csr_awprot  out  3  constant 3'b000
- csr_wvalid / csr_wready  out / in  1  AXI4-Lite W handshake
- csr_wdata  out  32  write data
- csr_wstrb  out  4  constant 4'hF
- csr_bvalid / csr_bready  in / out  1  AXI4-Lite B handshake
- csr_bresp  in  2  write response
- busy_o  out  1  sequence in progress
- done_o  out  1  one-cycle pulse at sequence end
- err_o  out  1  sticky error, at least one non-OKAY bresp

Function
REQ-007 SHALL implement FSM states IDLE, FETCH, WRITE, RESP, APPLY, APPLY_RESP, DONE.
REQ-008 IDLE: start_i=1 -> FETCH, index k cleared to 0, err_o cleared; otherwise remain in IDLE.
REQ-009 FETCH: coef_i_tready=1; on tvalid&tready latch the coefficient -> WRITE; coef_i_tready SHALL be 0 in every other state.
REQ-010 WRITE: assert csr_awvalid and csr_wvalid in the same first cycle; awaddr = CSR_BASE_ADDR + 4*k; wdata = coefficient sign-extended to 32 bits.
REQ-011 Each of awvalid and wvalid SHALL stay high until its own ready is sampled high, then drop independently; addr/data SHALL stay stable while valid.
REQ-012 AW and W accepted in the same cycle, or in either order, SHALL all be legal; leave WRITE only after both are accepted -> RESP.
REQ-013 RESP: csr_bready=1; on bvalid, bresp!=2'b00 sets err_o; then k==N-1 -> APPLY, else k increments -> FETCH.
REQ-014 APPLY: same AW/W rules as REQ-011/012; awaddr = CSR_BASE_ADDR + APPLY_OFFSET, wdata = 32'h1 -> APPLY_RESP.
REQ-015 APPLY_RESP: same B rules as REQ-013 -> DONE.
REQ-016 DONE: done_o=1 for exactly one cycle -> IDLE.
REQ-017 busy_o=1 in every state except IDLE; start_i SHALL be ignored while busy_o=1.
REQ-018 The block SHALL have at most one outstanding write; bready=0 outside RESP and APPLY_RESP.
REQ-019 The index counter SHALL be ceil(log2(N)) bits wide and SHALL never exceed N-1.
REQ-020 Stalls of any length on coef_i_tvalid, awready, wready or bvalid SHALL only extend the state; they SHALL not cause data loss or duplication.

Reset
REQ-021 While rst_i=1, asynchronously: state=IDLE, k=0, and awvalid, wvalid, bready, coef_i_tready, busy_o, done_o and err_o all 0; awaddr and wdata 0.
REQ-022 Reset asserted mid-transaction SHALL drop all valids immediately; no partial sequence resumes after release.
REQ-023 The first start_i SHALL be honoured on the first rising clk_i edge after rst_i deasserts.

Verification
REQ-024 Nominal, WIN_SIZE=3, CSR_BASE_ADDR=0x40, coefficients -1,2,...,9, AW/W/B always ready -> 9 writes to 0x40..0x60, wdata 0xFFFFFFFF first, then an apply write to 0x140 of 0x1; one done_o pulse; err_o=0.
REQ-025 awready held low 5 cycles while wready=1 -> wvalid drops after 1 cycle, awvalid is held with a stable address, and exactly one B is awaited per write.
REQ-026 bresp=2'b10 on write k=4 -> err_o=1 from the next cycle through done_o, and the sequence still completes all N+1 writes.
REQ-027 coef_i_tvalid gapped randomly and start_i pulsed while busy -> coefficients are written in order with no duplicates; the extra start is ignored.
REQ-028 rst_i asserted during WRITE, then released, then start_i -> all outputs are 0 during reset, and the new sequence starts at k=0, address CSR_BASE_ADDR.
